// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes X - Y - borrowin one bit per cycle, LSB first,
// and publishes D/borrowout/overflow in a single registered update per operation.
module serial_subtractor #(
  parameter int n = 32
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic         start,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  input  logic         borrowin,
  output logic [n-1:0] D,
  output logic         borrowout,
  output logic         overflow,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [n-1:0]  r_x;
  logic [n-1:0]  r_y;
  logic [n-1:0]  r_diff;
  logic          r_b;
  logic          r_xmsb;
  logic          r_ymsb;
  logic          w_d;
  logic          w_b_next;
  logic          w_last;

  // The RUN cycle that sees the counter at n performs no bit; it publishes the results.
  assign w_last   = (r_cnt == CW'(n));
  assign w_d      = r_x[0] ^ r_y[0] ^ r_b;
  assign w_b_next = (~r_x[0] & r_y[0]) | (~(r_x[0] ^ r_y[0]) & r_b);

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_cnt     <= '0;
      r_x       <= '0;
      r_y       <= '0;
      r_diff    <= '0;
      r_b       <= 1'b0;
      r_xmsb    <= 1'b0;
      r_ymsb    <= 1'b0;
      D         <= '0;
      borrowout <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x    <= X;
            r_y    <= Y;
            r_b    <= borrowin;
            r_xmsb <= X[n-1];
            r_ymsb <= Y[n-1];
            r_cnt  <= '0;
          end
        end
        RUN: begin
          if (!w_last) begin
            r_x    <= {1'b0, r_x[n-1:1]};
            r_y    <= {1'b0, r_y[n-1:1]};
            r_diff <= {w_d, r_diff[n-1:1]};
            r_b    <= w_b_next;
            r_cnt  <= r_cnt + 1'b1;
          end else begin
            D         <= r_diff;
            borrowout <= r_b;
            overflow  <= (r_xmsb ^ r_ymsb) & (r_diff[n-1] ^ r_xmsb);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at n=8: arithmetic vectors, latency,
// start re-pulse, mid-operation reset and back-to-back operation.
module tb_serial_subtractor;

  localparam int N = 8;

  logic         Clock;
  logic         Resetn;
  logic         start;
  logic [N-1:0] X;
  logic [N-1:0] Y;
  logic         borrowin;
  logic [N-1:0] D;
  logic         borrowout;
  logic         overflow;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.n(N)) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .start    (start),
    .X        (X),
    .Y        (Y),
    .borrowin (borrowin),
    .D        (D),
    .borrowout(borrowout),
    .overflow (overflow),
    .busy     (busy),
    .done     (done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Presents operands with start and returns 1 ns after the accepting edge.
  task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic b);
    X = x; Y = y; borrowin = b; start = 1'b1;
    @(posedge Clock); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b1; start = 1'b0; X = '0; Y = '0; borrowin = 1'b0;
    #1 Resetn = 1'b0;
    #2;
    checks++;
    if ({D, borrowout, overflow, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required 0", {D, borrowout, overflow, busy, done});
    end
    start = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    checks++;
    if ({D, borrowout, overflow, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_held: outputs=%h required 0", {D, borrowout, overflow, busy, done});
    end
    start = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_arith();
    logic [N-1:0] vx [7] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'hA5};
    logic [N-1:0] vy [7] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h5A};
    logic         vb [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [N-1:0] ed [7] = '{8'h02, 8'hFE, 8'h7F, 8'h80, 8'hFF, 8'hFF, 8'h4B};
    logic         eb [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic         eo [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      int k;
      k = 0;
      start_op(vx[i], vy[i], vb[i]);
      for (int c = 1; c <= 20; c++) begin
        @(posedge Clock); #1;
        if (done) begin k = c; break; end
      end
      checks++;
      if (k !== N + 1) begin
        errors++;
        $display("FAIL arith_latency[%0d]: edges=%0d required %0d", i, k, N + 1);
      end
      checks++;
      if (D !== ed[i]) begin
        errors++;
        $display("FAIL arith_D[%0d]: D=%h required %h", i, D, ed[i]);
      end
      checks++;
      if (borrowout !== eb[i]) begin
        errors++;
        $display("FAIL arith_borrow[%0d]: borrowout=%b required %b", i, borrowout, eb[i]);
      end
      checks++;
      if (overflow !== eo[i]) begin
        errors++;
        $display("FAIL arith_overflow[%0d]: overflow=%b required %b", i, overflow, eo[i]);
      end
      @(posedge Clock); #1;
      checks++;
      if ({busy, done} !== 2'b00) begin
        errors++;
        $display("FAIL arith_idle[%0d]: busy,done=%b required 00", i, {busy, done});
      end
      $display("arith %h - %h - %b -> D=%h bo=%b ov=%b after %0d edges",
               vx[i], vy[i], vb[i], D, borrowout, overflow, k);
    end
  endtask

  task automatic test_repulse();
    int dones;
    int busy_low;
    dones = 0;
    busy_low = 0;
    start_op(8'h05, 8'h03, 1'b0);
    for (int c = 1; c <= 14; c++) begin
      if (c == 3) begin
        X = 8'hFF; Y = 8'h00; borrowin = 1'b1; start = 1'b1;
      end
      @(posedge Clock); #1;
      start = 1'b0;
      if (done) dones++;
      if (c <= N + 1 && !busy) busy_low++;
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL repulse_dones: pulses=%0d required 1", dones);
    end
    checks++;
    if (busy_low !== 0) begin
      errors++;
      $display("FAIL repulse_busy: busy-low cycles=%0d required 0", busy_low);
    end
    checks++;
    if ({D, borrowout, overflow} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL repulse_result: D,bo,ov=%h required %h", {D, borrowout, overflow}, {8'h02, 2'b00});
    end
    $display("repulse: done pulses=%0d D=%h", dones, D);
  endtask

  task automatic test_mid_reset();
    int dones;
    int k;
    dones = 0;
    k = 0;
    start_op(8'h03, 8'h05, 1'b0);
    repeat (4) @(posedge Clock);
    #1 Resetn = 1'b0;
    #1;
    checks++;
    if (D !== 8'h00) begin
      errors++;
      $display("FAIL midreset_D: D=%h required 00", D);
    end
    checks++;
    if ({borrowout, overflow, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: bo,ov,busy,done=%b required 0000", {borrowout, overflow, busy, done});
    end
    for (int c = 0; c < 12; c++) begin
      @(posedge Clock); #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL midreset_nodone: pulses=%0d required 0", dones);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    start_op(8'h80, 8'h01, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midreset_accept: busy=%b required 1", busy);
    end
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clock); #1;
      if (done) begin k = c; break; end
    end
    checks++;
    if (k !== N + 1 || {D, borrowout, overflow} !== {8'h7F, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL midreset_after: edges=%0d D,bo,ov=%h required 9 and %h",
               k, {D, borrowout, overflow}, {8'h7F, 2'b01});
    end
    @(posedge Clock); #1;
    $display("mid_reset: new op D=%h ov=%b after %0d edges", D, overflow, k);
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    start_op(8'h03, 8'h05, 1'b0);
    for (int c = 1; c <= 20; c++) begin
      @(posedge Clock); #1;
      if (done) begin k = c; break; end
    end
    checks++;
    if (k !== N + 1 || D !== 8'hFE) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d D=%h required 9 and FE", k, D);
    end
    X = 8'h05; Y = 8'h03; borrowin = 1'b0; start = 1'b1;
    @(posedge Clock); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_ignore_in_done: busy,done=%b required 00", {busy, done});
    end
    @(posedge Clock); #1;
    start = 1'b0;
    X = 8'hAA; Y = 8'h11; borrowin = 1'b1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b required 1", busy);
    end
    repeat (4) @(posedge Clock);
    #1;
    checks++;
    if ({D, borrowout} !== {8'hFE, 1'b1}) begin
      errors++;
      $display("FAIL b2b_hold: D,bo=%h required %h", {D, borrowout}, {8'hFE, 1'b1});
    end
    k = 0;
    for (int c = 5; c <= 20; c++) begin
      @(posedge Clock); #1;
      if (done) begin k = c; break; end
    end
    checks++;
    if (k !== N + 1 || {D, borrowout, overflow} !== {8'h02, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d D,bo,ov=%h required 9 and %h",
               k, {D, borrowout, overflow}, {8'h02, 2'b00});
    end
    @(posedge Clock); #1;
    $display("back_to_back: second D=%h after %0d edges", D, k);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_repulse();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
